// File: rtl/exibidor_saida_pkg.sv
// Shared types and constants for the output display stage: FSM states, range limit,
// digit count and active-high 7-segment glyphs ({g,f,e,d,c,b,a}).
package exibidor_pkg;
   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONVERTE = 2'd1,
      CARREGA  = 2'd2
   } estado_t;

   localparam logic [31:0] LIMITE    = 32'd99_999_999;
   localparam int          BITS_MAG  = 27;
   localparam int          N_DIGITOS = 8;

   localparam logic [6:0] SEG_0      = 7'b0111111;
   localparam logic [6:0] SEG_1      = 7'b0000110;
   localparam logic [6:0] SEG_2      = 7'b1011011;
   localparam logic [6:0] SEG_3      = 7'b1001111;
   localparam logic [6:0] SEG_4      = 7'b1100110;
   localparam logic [6:0] SEG_5      = 7'b1101101;
   localparam logic [6:0] SEG_6      = 7'b1111101;
   localparam logic [6:0] SEG_7      = 7'b0000111;
   localparam logic [6:0] SEG_8      = 7'b1111111;
   localparam logic [6:0] SEG_9      = 7'b1101111;
   localparam logic [6:0] SEG_BRANCO = 7'b0000000;
   localparam logic [6:0] SEG_TRACO  = 7'b1000000;

   function automatic logic [6:0] seg_digito(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BRANCO;
      endcase
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [4*N_DIGITOS-1:0] soma3(input logic [4*N_DIGITOS-1:0] bcd);
      logic [4*N_DIGITOS-1:0] r;
      r = bcd;
      for (int k = 0; k < N_DIGITOS; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction
endpackage

// File: rtl/exibidor_saida_decodificador_7seg.sv
// Combinational BCD to 7-segment decoder with blanking, dash override and
// selectable output polarity.
module decodificador_7seg
   import exibidor_pkg::*;
#(
   parameter logic ATIVO_BAIXO = 1'b1
) (
   input  logic [3:0] bcd,
   input  logic       apaga,
   input  logic       traco,
   output logic [6:0] seg
);
   logic [6:0] seg_alto;

   always_comb begin
      if (traco)      seg_alto = SEG_TRACO;
      else if (apaga) seg_alto = SEG_BRANCO;
      else            seg_alto = seg_digito(bcd);
   end

   assign seg = ATIVO_BAIXO ? ~seg_alto : seg_alto;
endmodule

// File: rtl/exibidor_saida.sv
// Print display stage: edge-detects print_out, converts |value| to BCD by
// sequential double-dabble and drives eight static 7-segment digits.
module exibidor_saida
   import exibidor_pkg::*;
#(
   parameter logic ATIVO_BAIXO = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        print_out,
   input  logic [31:0] print_dados,
   output logic [55:0] segmentos,
   output logic        sinal,
   output logic        erro,
   output logic        ocupado,
   output logic        valido,
   output logic        perdeu_amostra
);
   localparam int W_BCD = 4*N_DIGITOS;
   localparam int W_SEG = 7*N_DIGITOS;

   logic                amostra_print_q, amostra_print_d, print_ant_q, print_ant_d;
   logic [31:0]         amostra_dados_q, amostra_dados_d;
   estado_t             estado_q, estado_d;
   logic [4:0]          cont_q, cont_d;
   logic [W_BCD-1:0]    bcd_q, bcd_d;
   logic [BITS_MAG-1:0] bin_q, bin_d;
   logic                neg_q, neg_d, fora_q, fora_d;
   logic                pend_valido_q, pend_valido_d, pend_neg_q, pend_neg_d;
   logic                pend_fora_q, pend_fora_d;
   logic [BITS_MAG-1:0] pend_mag_q, pend_mag_d;
   logic [W_SEG-1:0]    segmentos_q, segmentos_d, seg_dec;
   logic                sinal_q, sinal_d, erro_q, erro_d, valido_q, valido_d;
   logic                perdeu_q, perdeu_d;

   logic                strobe, novo_neg, novo_fora;
   logic [31:0]         novo_abs;
   logic [N_DIGITOS-1:0] apaga;

   assign strobe    = amostra_print_q & ~print_ant_q;
   assign novo_neg  = amostra_dados_q[31];
   assign novo_abs  = novo_neg ? (~amostra_dados_q + 32'd1) : amostra_dados_q;
   assign novo_fora = novo_abs > LIMITE;

   // Leading-zero blanking: digit k is blank when it and every digit above are zero.
   always_comb begin
      apaga = '0;
      apaga[N_DIGITOS-1] = (bcd_q[W_BCD-1 -: 4] == 4'd0);
      for (int k = N_DIGITOS-2; k >= 1; k--) begin
         apaga[k] = apaga[k+1] & (bcd_q[4*k +: 4] == 4'd0);
      end
   end

   for (genvar k = 0; k < N_DIGITOS; k++) begin : g_dig
      decodificador_7seg #(.ATIVO_BAIXO(ATIVO_BAIXO)) u_dec (
         .bcd   (bcd_q[4*k +: 4]),
         .apaga (apaga[k]),
         .traco (fora_q),
         .seg   (seg_dec[7*k +: 7])
      );
   end

   always_comb begin
      amostra_print_d = print_out;
      amostra_dados_d = print_dados;
      print_ant_d     = amostra_print_q;
      estado_d        = estado_q;
      cont_d          = cont_q;
      bcd_d           = bcd_q;
      bin_d           = bin_q;
      neg_d           = neg_q;
      fora_d          = fora_q;
      pend_valido_d   = pend_valido_q;
      pend_neg_d      = pend_neg_q;
      pend_mag_d      = pend_mag_q;
      pend_fora_d     = pend_fora_q;
      segmentos_d     = segmentos_q;
      sinal_d         = sinal_q;
      erro_d          = erro_q;
      valido_d        = 1'b0;
      perdeu_d        = perdeu_q;

      if (strobe && estado_q != OCIOSO) begin
         perdeu_d      = perdeu_q | pend_valido_q;
         pend_valido_d = 1'b1;
         pend_neg_d    = novo_neg;
         pend_mag_d    = novo_abs[BITS_MAG-1:0];
         pend_fora_d   = novo_fora;
      end

      case (estado_q)
         OCIOSO: begin
            if (strobe) begin
               estado_d = CONVERTE;
               cont_d   = 5'd0;
               bcd_d    = '0;
               bin_d    = novo_abs[BITS_MAG-1:0];
               neg_d    = novo_neg;
               fora_d   = novo_fora;
            end
         end
         CONVERTE: begin
            {bcd_d, bin_d} = {soma3(bcd_q), bin_q} << 1;
            if (cont_q == 5'(BITS_MAG-1)) estado_d = CARREGA;
            else                          cont_d   = cont_q + 5'd1;
         end
         CARREGA: begin
            segmentos_d = seg_dec;
            erro_d      = fora_q;
            sinal_d     = neg_q & ~fora_q;
            valido_d    = 1'b1;
            // A strobe landing on this edge was just queued above, so it is taken here too.
            if (pend_valido_d) begin
               estado_d      = CONVERTE;
               cont_d        = 5'd0;
               bcd_d         = '0;
               bin_d         = pend_mag_d;
               neg_d         = pend_neg_d;
               fora_d        = pend_fora_d;
               pend_valido_d = 1'b0;
            end else begin
               estado_d = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         amostra_print_q <= 1'b0;
         amostra_dados_q <= '0;
         print_ant_q     <= 1'b0;
         estado_q        <= OCIOSO;
         cont_q          <= '0;
         bcd_q           <= '0;
         bin_q           <= '0;
         neg_q           <= 1'b0;
         fora_q          <= 1'b0;
         pend_valido_q   <= 1'b0;
         pend_neg_q      <= 1'b0;
         pend_mag_q      <= '0;
         pend_fora_q     <= 1'b0;
         segmentos_q     <= {W_SEG{ATIVO_BAIXO}};
         sinal_q         <= 1'b0;
         erro_q          <= 1'b0;
         valido_q        <= 1'b0;
         perdeu_q        <= 1'b0;
      end else begin
         amostra_print_q <= amostra_print_d;
         amostra_dados_q <= amostra_dados_d;
         print_ant_q     <= print_ant_d;
         estado_q        <= estado_d;
         cont_q          <= cont_d;
         bcd_q           <= bcd_d;
         bin_q           <= bin_d;
         neg_q           <= neg_d;
         fora_q          <= fora_d;
         pend_valido_q   <= pend_valido_d;
         pend_neg_q      <= pend_neg_d;
         pend_mag_q      <= pend_mag_d;
         pend_fora_q     <= pend_fora_d;
         segmentos_q     <= segmentos_d;
         sinal_q         <= sinal_d;
         erro_q          <= erro_d;
         valido_q        <= valido_d;
         perdeu_q        <= perdeu_d;
      end
   end

   assign segmentos      = segmentos_q;
   assign sinal          = sinal_q;
   assign erro           = erro_q;
   assign valido         = valido_q;
   assign perdeu_amostra = perdeu_q;
   assign ocupado        = (estado_q != OCIOSO);
endmodule

// File: tb/tb_exibidor_saida.sv
// Self-checking bench for exibidor_saida: directed and random values against an
// arithmetic decimal-display model, plus timing, overwrite, hold and reset scenarios.
module tb_exibidor_saida;
   logic        clock = 1'b0;
   logic        reset, print_out;
   logic [31:0] print_dados;
   logic [55:0] segmentos;
   logic        sinal, erro, ocupado, valido, perdeu_amostra;
   int          total = 0;
   int          bad = 0;

   always #5 clock = ~clock;

   exibidor_saida #(.ATIVO_BAIXO(1'b1)) dut (
      .clock          (clock),
      .reset          (reset),
      .print_out      (print_out),
      .print_dados    (print_dados),
      .segmentos      (segmentos),
      .sinal          (sinal),
      .erro           (erro),
      .ocupado        (ocupado),
      .valido         (valido),
      .perdeu_amostra (perdeu_amostra)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
      total++;
      assert (obs === esp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   // Active-high glyph per decimal digit, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glifo(input longint d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         default: return 7'b1101111;
      endcase
   endfunction

   function automatic longint modulo(input logic [31:0] v);
      longint m;
      m = longint'($signed(v));
      return (m < 0) ? -m : m;
   endfunction

   function automatic logic modelo_fora(input logic [31:0] v);
      return modulo(v) > 64'sd99_999_999;
   endfunction

   function automatic logic [55:0] modelo_seg(input logic [31:0] v);
      logic [55:0] s;
      longint m, p;
      m = modulo(v);
      p = 1;
      for (int k = 0; k < 8; k++) begin
         if (m > 99_999_999)      s[7*k +: 7] = ~7'b1000000;
         else if (k > 0 && m < p) s[7*k +: 7] = 7'b1111111;
         else                     s[7*k +: 7] = ~glifo((m / p) % 10);
         p = p * 10;
      end
      return s;
   endfunction

   task automatic confere_display(input string tag, input logic [31:0] v);
      verifica({tag, " segmentos"}, segmentos, modelo_seg(v));
      verifica({tag, " sinal"}, sinal, (!modelo_fora(v) && v[31]));
      verifica({tag, " erro"}, erro, modelo_fora(v));
   endtask

   task automatic confere_reset(input string tag);
      verifica({tag, " segmentos"}, segmentos, {56{1'b1}});
      verifica({tag, " sinal"}, sinal, 0);
      verifica({tag, " erro"}, erro, 0);
      verifica({tag, " ocupado"}, ocupado, 0);
      verifica({tag, " valido"}, valido, 0);
      verifica({tag, " perdeu"}, perdeu_amostra, 0);
   endtask

   task automatic pulso_reset;
      reset = 1'b1;
      print_out = 1'b0;
      tick;
      reset = 1'b0;
   endtask

   task automatic converte(input logic [31:0] v, input string tag);
      int n;
      print_dados = v;
      print_out = 1'b1;
      tick;
      print_out = 1'b0;
      tick;
      n = 1;
      verifica({tag, " ocupado"}, ocupado, 1);
      while (!valido && n < 60) begin
         tick;
         n++;
      end
      verifica({tag, " latencia"}, n, 29);
      confere_display(tag, v);
      tick;
      verifica({tag, " pulso"}, valido, 0);
      verifica({tag, " fim"}, ocupado, 0);
   endtask

   initial begin
      logic [31:0] v;
      int          n, nval;

      reset = 1'b1;
      print_out = 1'b0;
      print_dados = '0;
      tick;
      tick;
      reset = 1'b0;
      confere_reset("reset");

      converte(32'd1234, "1234");
      verifica("1234 digito3", segmentos[27:21], 7'b1111001);
      verifica("1234 digito7", segmentos[55:49], 7'b1111111);
      converte(32'hFFFF_FFFB, "menos5");
      converte(32'd99_999_999, "limite");
      converte(32'd100_000_000, "acima");
      converte(32'h8000_0000, "minint");
      converte(-32'sd99_999_999, "limite_neg");
      converte(-32'sd100_000_000, "acima_neg");
      converte(32'd0, "zero");

      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom();
            1:       v = $urandom_range(0, 99_999_999);
            2:       v = -$urandom_range(0, 99_999_999);
            default: v = $urandom_range(0, 999);
         endcase
         converte(v, "aleatorio");
      end

      // Strobes 7, 8, 9 at E0, E5, E10: 8 is overwritten while pending.
      pulso_reset;
      verifica("seq perdeu inicial", perdeu_amostra, 0);
      nval = 0;
      for (int c = 0; c < 80; c++) begin
         print_out = (c == 0 || c == 5 || c == 10);
         print_dados = (c < 5) ? 32'd7 : (c < 10) ? 32'd8 : 32'd9;
         tick;
         if (valido) begin
            nval++;
            verifica("seq instante", c, (nval == 1) ? 29 : 57);
            confere_display("seq", (c < 40) ? 32'd7 : 32'd9);
         end
      end
      print_out = 1'b0;
      verifica("seq contagem", nval, 2);
      verifica("seq perdeu", perdeu_amostra, 1);

      pulso_reset;
      nval = 0;
      print_dados = 32'd42;
      print_out = 1'b1;
      for (int c = 0; c < 140; c++) begin
         if (c == 100) print_out = 1'b0;
         tick;
         if (valido) nval++;
      end
      verifica("nivel contagem", nval, 1);
      confere_display("nivel", 32'd42);

      // Reset at E15 abandons the conversion.
      pulso_reset;
      print_dados = 32'd555;
      print_out = 1'b1;
      tick;
      print_out = 1'b0;
      repeat (14) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      nval = 0;
      for (int c = 0; c < 40; c++) begin
         tick;
         if (valido) nval++;
      end
      verifica("abortado valido", nval, 0);
      confere_reset("abortado");
      converte(32'd77, "pos_reset");

      // print_out high across reset release: E0 is the first edge after release.
      reset = 1'b1;
      print_dados = 32'd321;
      print_out = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      print_out = 1'b0;
      n = 0;
      while (!valido && n < 60) begin
         tick;
         n++;
      end
      verifica("atravessa latencia", n, 29);
      confere_display("atravessa", 32'd321);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
